alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Operand-select pipeline stage between instruction decode and the ALU. It latches decoded operands A/B, carry-in and CR word into a one-entry pipeline register. It forwards in-flight results from the EX and WB stages into those operands and stalls decode on an unresolved EX hazard. It presents the finished operands to the ALU with a valid/ready handshake.

Parameters:
DWIDTH, 32, operand/result width (matches Word)
RADDR_W, 5, GPR address width (32 GPRs)
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  stage clock
reset  in  1  asynchronous active-high reset
flush  in  1  discard stage contents (branch/interrupt)
dec_valid  in  1  decode offers an instruction
dec_ready  out  1  stage accepts this cycle
dec_a, dec_b  in  DWIDTH  operand values read by decode (GPR file or immediate)
dec_a_reg, dec_b_reg  in  RADDR_W  source GPR of A/B
dec_a_use, dec_b_use  in  1  operand comes from a GPR (forwarding applies)
dec_cin  in  1  carry-in
dec_cr  in  DWIDTH  condition register word
dec_dest  in  RADDR_W  destination GPR
dec_dest_wr  in  1  instruction writes dec_dest
ex_wr  in  1  EX stage holds an instruction writing ex_dest
ex_dest  in  RADDR_W  EX destination
ex_res_valid  in  1  EX result available this cycle (0 for multicycle/load pending)
ex_res  in  DWIDTH  EX result
wb_wr  in  1  WB writes wb_dest this cycle
wb_dest  in  RADDR_W  WB destination
wb_res  in  DWIDTH  WB result
alu_valid  out  1  operands valid for ALU
alu_ready  in  1  ALU consumes this cycle
alu_a, alu_b  out  DWIDTH  final operands
alu_cin  out  1  carry-in
alu_cr  out  DWIDTH  CR word
alu_dest  out  RADDR_W  destination GPR
alu_dest_wr  out  1  destination write enable
stall_cnt  out  STALL_CNT_W  cycles with dec_valid=1 and dec_ready=0, saturating

Behaviour:
- Reset, async: alu_valid=0; alu_a/alu_b/alu_cr/alu_dest=0; alu_cin=0; alu_dest_wr=0; stall_cnt=0; state=EMPTY. dec_ready=0 while reset is high.
- States: EMPTY (alu_valid=0) and FULL (alu_valid=1).
  - EMPTY->FULL on load.
  - FULL->EMPTY on alu_ready without load.
  - FULL->FULL on alu_ready with load, or on hold.
  - Any state->EMPTY on flush.
- Per-operand match: X_use=1 and X_reg equals the stage's dest with its write enable set.
  - ex_hit: dec_X_use and ex_wr and ex_dest==dec_X_reg.
  - wb_hit: same test against wb_wr/wb_dest.
- Operand mux priority: ex_hit (ex_res) > wb_hit (wb_res) > dec_X.
- hazard = (ex_hit on A or B) and ex_res_valid=0.
- dec_ready = !reset & !flush & !hazard & (state==EMPTY | alu_ready). Purely combinational, no registered delay.
- load = dec_valid & dec_ready. Registers the muxed operands, dec_cin, dec_cr, dec_dest, dec_dest_wr and the source reg/use fields. Latency decode->ALU is 1 cycle.
- Hold (FULL & !alu_ready & !flush):
  - Outputs stay stable.
  - Exception: a held operand with use=1 whose reg matches wb_dest with wb_wr=1 is overwritten with wb_res that edge. This snoop ignores EX.
- flush has priority over load and hold. Next cycle alu_valid=0 and the decode offer is dropped (dec_ready=0).
- Simultaneous FULL & alu_ready & dec_valid & !hazard: back-to-back transfer with no bubble.
- stall_cnt increments when dec_valid & !dec_ready & !reset. It saturates at all-ones and never wraps. flush does not clear it.
- alu_valid must never drop without alu_ready or flush. Held payload changes only via the WB snoop.

Decomposition:
- Pu_types gains the Gpr_addr typedef (logic [RADDR_W-1:0]) and an Operand_fwd_sel enum {FWD_DEC, FWD_WB, FWD_EX}.
- Word is reused for all DWIDTH signals.
- One natural sub-module, alu_fwd_mux. It is instantiated twice (A, B) and takes use/reg/dec value plus the EX/WB buses. It returns the operand, Operand_fwd_sel, ex_hit and wb_hit.
- alu_operand_stage keeps the state register, handshake, hazard logic, snoop and counter.

Test Plan:
- Reset mid-FULL: load A=0x11, B=0x22, then pulse reset -> alu_valid=0, alu_a=0, stall_cnt=0, dec_ready=0 during reset.
- Plain pass, alu_ready=1: dec_a=0x1234, dec_b=0x5678, no reg use -> next cycle alu_valid=1, alu_a=0x1234, alu_b=0x5678; 4 back-to-back instrs give 4 consecutive valid cycles.
- Forward priority: dec_a_reg=3, ex_wr=1, ex_dest=3, ex_res=0xAAAA, ex_res_valid=1, wb_wr=1, wb_dest=3, wb_res=0xBBBB -> alu_a=0xAAAA.
  - With ex_wr=0 -> alu_a=0xBBBB.
- EX hazard: dec_b_reg=7, ex_dest=7, ex_res_valid=0 for 3 cycles, then 1 with ex_res=0x55 -> dec_ready=0 for 3 cycles, stall_cnt=3, then alu_b=0x55.
- Hold + WB snoop: FULL with alu_a reg 4, alu_ready=0; wb_wr=1, wb_dest=4, wb_res=0x99 -> alu_a becomes 0x99 next cycle, other fields unchanged, alu_valid stays 1.
- Flush vs load: FULL, alu_ready=1, dec_valid=1, flush=1 -> dec_ready=0, next cycle alu_valid=0.
  - Stall_cnt saturation: force 65540 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared types for the ALU operand-select stage.
// Combinational definitions only; no latency.
// No flow control of its own.
package alu_operand_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int STALL_W    = 16;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  // Which source produced a final operand.
  typedef enum logic [1:0] {
    FWD_DEC = 2'd0,
    FWD_WB  = 2'd1,
    FWD_EX  = 2'd2
  } operand_fwd_sel_t;

  // One-entry pipeline register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-operand forwarding mux: EX result beats WB result beats decode value.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether an EX hit without a result stalls.
// Ports: src_use/src_reg/dec_val describe the decoded operand; ex_*/wb_* are the
//        in-flight result buses; operand/sel/ex_hit/wb_hit are the results.
module alu_fwd_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int DWIDTH  = WORD_W,
  parameter int RADDR_W = GPR_ADDR_W
) (
  input  logic               src_use,
  input  logic [RADDR_W-1:0] src_reg,
  input  logic [DWIDTH-1:0]  dec_val,
  input  logic               ex_wr,
  input  logic [RADDR_W-1:0] ex_dest,
  input  logic [DWIDTH-1:0]  ex_res,
  input  logic               wb_wr,
  input  logic [RADDR_W-1:0] wb_dest,
  input  logic [DWIDTH-1:0]  wb_res,
  output logic [DWIDTH-1:0]  operand,
  output operand_fwd_sel_t   sel,
  output logic               ex_hit,
  output logic               wb_hit
);

  assign ex_hit = src_use & ex_wr & (ex_dest == src_reg);
  assign wb_hit = src_use & wb_wr & (wb_dest == src_reg);

  always_comb begin
    sel     = FWD_DEC;
    operand = dec_val;
    if (ex_hit) begin
      sel     = FWD_EX;
      operand = ex_res;
    end else if (wb_hit) begin
      sel     = FWD_WB;
      operand = wb_res;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-select stage: forwards EX/WB results into decoded operands and holds them for the ALU.
// Latency: one cycle decode -> ALU; back-to-back transfers with no bubble.
// Backpressure: dec_ready drops on ALU stall, unresolved EX hazard, flush or reset.
// Ports: dec_* decode offer (valid/ready), ex_*/wb_* forwarding buses,
//        alu_* registered operands to the ALU (valid/ready), flush, stall_cnt.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DWIDTH      = WORD_W,
  parameter int RADDR_W     = GPR_ADDR_W,
  parameter int STALL_CNT_W = STALL_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [DWIDTH-1:0]      dec_a,
  input  logic [DWIDTH-1:0]      dec_b,
  input  logic [RADDR_W-1:0]     dec_a_reg,
  input  logic [RADDR_W-1:0]     dec_b_reg,
  input  logic                   dec_a_use,
  input  logic                   dec_b_use,
  input  logic                   dec_cin,
  input  logic [DWIDTH-1:0]      dec_cr,
  input  logic [RADDR_W-1:0]     dec_dest,
  input  logic                   dec_dest_wr,
  input  logic                   ex_wr,
  input  logic [RADDR_W-1:0]     ex_dest,
  input  logic                   ex_res_valid,
  input  logic [DWIDTH-1:0]      ex_res,
  input  logic                   wb_wr,
  input  logic [RADDR_W-1:0]     wb_dest,
  input  logic [DWIDTH-1:0]      wb_res,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic [DWIDTH-1:0]      alu_a,
  output logic [DWIDTH-1:0]      alu_b,
  output logic                   alu_cin,
  output logic [DWIDTH-1:0]      alu_cr,
  output logic [RADDR_W-1:0]     alu_dest,
  output logic                   alu_dest_wr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  stage_state_t state_q, state_d;

  logic [DWIDTH-1:0]      fwd_a, fwd_b;
  operand_fwd_sel_t       sel_a, sel_b;
  logic                   ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

  // Source fields of the held operands, kept so the WB snoop can refresh them.
  logic [RADDR_W-1:0]     a_reg_q, b_reg_q;
  logic                   a_use_q, b_use_q;

  logic hazard, load, hold, snoop_a, snoop_b;

  alu_fwd_mux #(.DWIDTH(DWIDTH), .RADDR_W(RADDR_W)) u_fwd_a (
    .src_use (dec_a_use), .src_reg (dec_a_reg), .dec_val (dec_a),
    .ex_wr   (ex_wr),     .ex_dest (ex_dest),   .ex_res  (ex_res),
    .wb_wr   (wb_wr),     .wb_dest (wb_dest),   .wb_res  (wb_res),
    .operand (fwd_a),     .sel     (sel_a),
    .ex_hit  (ex_hit_a),  .wb_hit  (wb_hit_a)
  );

  alu_fwd_mux #(.DWIDTH(DWIDTH), .RADDR_W(RADDR_W)) u_fwd_b (
    .src_use (dec_b_use), .src_reg (dec_b_reg), .dec_val (dec_b),
    .ex_wr   (ex_wr),     .ex_dest (ex_dest),   .ex_res  (ex_res),
    .wb_wr   (wb_wr),     .wb_dest (wb_dest),   .wb_res  (wb_res),
    .operand (fwd_b),     .sel     (sel_b),
    .ex_hit  (ex_hit_b),  .wb_hit  (wb_hit_b)
  );

  // Source selects and WB hits are trace/debug information; the control
  // path only needs the EX hits.
  logic unused_fwd_info;
  assign unused_fwd_info = ^{sel_a, sel_b, wb_hit_a, wb_hit_b};

  // An EX producer that has not finished yet cannot be forwarded; WB would
  // hold a stale value for that register, so the decode offer must wait.
  assign hazard    = (ex_hit_a | ex_hit_b) & ~ex_res_valid;
  assign dec_ready = ~reset & ~flush & ~hazard & ((state_q == EMPTY) | alu_ready);
  assign load      = dec_valid & dec_ready;
  assign hold      = (state_q == FULL) & ~alu_ready & ~flush;

  // While held, a WB write to a source register replaces the stale value.
  // EX is not snooped: an EX result reaches WB before the entry can leave.
  assign snoop_a = a_use_q & wb_wr & (wb_dest == a_reg_q);
  assign snoop_b = b_use_q & wb_wr & (wb_dest == b_reg_q);

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = EMPTY;
    else if (load)
      state_d = FULL;
    else if ((state_q == FULL) && alu_ready)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  assign alu_valid = (state_q == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cin     <= 1'b0;
      alu_cr      <= '0;
      alu_dest    <= '0;
      alu_dest_wr <= 1'b0;
      a_reg_q     <= '0;
      b_reg_q     <= '0;
      a_use_q     <= 1'b0;
      b_use_q     <= 1'b0;
    end else if (load) begin
      alu_a       <= fwd_a;
      alu_b       <= fwd_b;
      alu_cin     <= dec_cin;
      alu_cr      <= dec_cr;
      alu_dest    <= dec_dest;
      alu_dest_wr <= dec_dest_wr;
      a_reg_q     <= dec_a_reg;
      b_reg_q     <= dec_b_reg;
      a_use_q     <= dec_a_use;
      b_use_q     <= dec_b_use;
    end else if (hold) begin
      if (snoop_a) alu_a <= wb_res;
      if (snoop_b) alu_b <= wb_res;
    end
  end

  // Saturating count of cycles where decode offered but was refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (dec_valid && !dec_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush, dec_valid, dec_ready;
  logic [31:0] dec_a, dec_b, dec_cr, ex_res, wb_res;
  logic [4:0]  dec_a_reg, dec_b_reg, dec_dest, ex_dest, wb_dest;
  logic        dec_a_use, dec_b_use, dec_cin, dec_dest_wr;
  logic        ex_wr, ex_res_valid, wb_wr;
  logic        alu_valid, alu_ready, alu_cin, alu_dest_wr;
  logic [31:0] alu_a, alu_b, alu_cr;
  logic [4:0]  alu_dest;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_a(dec_a), .dec_b(dec_b), .dec_a_reg(dec_a_reg), .dec_b_reg(dec_b_reg),
    .dec_a_use(dec_a_use), .dec_b_use(dec_b_use), .dec_cin(dec_cin), .dec_cr(dec_cr),
    .dec_dest(dec_dest), .dec_dest_wr(dec_dest_wr),
    .ex_wr(ex_wr), .ex_dest(ex_dest), .ex_res_valid(ex_res_valid), .ex_res(ex_res),
    .wb_wr(wb_wr), .wb_dest(wb_dest), .wb_res(wb_res),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_cr(alu_cr), .alu_dest(alu_dest), .alu_dest_wr(alu_dest_wr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 0; dec_valid = 0; dec_a = 0; dec_b = 0; dec_a_reg = 0; dec_b_reg = 0;
    dec_a_use = 0; dec_b_use = 0; dec_cin = 0; dec_cr = 0; dec_dest = 0; dec_dest_wr = 0;
    ex_wr = 0; ex_dest = 0; ex_res_valid = 1; ex_res = 0;
    wb_wr = 0; wb_dest = 0; wb_res = 0; alu_ready = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [31:0] a, b, cr;
    logic        cin, dest_wr, a_use, b_use;
    logic [4:0]  dest, a_reg, b_reg;
  } entry_t;

  function automatic bit m_hit(logic u, logic [4:0] r, logic wr, logic [4:0] d);
    return (u === 1'b1) && (wr === 1'b1) && (r === d);
  endfunction

  // Newest value of a register operand as seen by decode this cycle.
  function automatic logic [31:0] m_value(logic u, logic [4:0] r, logic [31:0] v);
    if (m_hit(u, r, ex_wr, ex_dest)) return ex_res;
    if (m_hit(u, r, wb_wr, wb_dest)) return wb_res;
    return v;
  endfunction

  // ---------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    dec_valid = 1;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %b want 0", dec_ready); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %b want 0", alu_valid); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
    tick();
    reset = 0;
    dec_a = 32'h11; dec_b = 32'h22; alu_ready = 0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_exit_ready: got %b want 1", dec_ready); end
    tick();
    dec_valid = 0;
    checks++; if (alu_valid !== 1'b1 || alu_a !== 32'h11 || alu_b !== 32'h22) begin
      errors++; $display("FAIL reset_preload: valid=%b a=%h b=%h want 1/11/22", alu_valid, alu_a, alu_b); end
    // asynchronous reset pulse in the middle of the cycle
    #2 reset = 1;
    dec_valid = 1;
    #1;
    checks++; if (alu_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      errors++; $display("FAIL reset_mid_full: valid=%b a=%h b=%h want 0/0/0", alu_valid, alu_a, alu_b); end
    checks++; if (stall_cnt !== 16'h0 || dec_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ctrl: stall=%h ready=%b want 0/0", stall_cnt, dec_ready); end
    tick();
    reset = 0;
    drive_idle();
    tick();
  endtask

  task automatic test_pass();
    int streak = 0;
    drive_idle();
    alu_ready = 1;
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1; dec_a = 32'h1234 + i; dec_b = 32'h5678 + i;
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL pass_ready[%0d]: got %b want 1", i, dec_ready); end
      tick();
      if (alu_valid === 1'b1) streak++;
      checks++; if (alu_a !== 32'h1234 + i || alu_b !== 32'h5678 + i) begin
        errors++; $display("FAIL pass_data[%0d]: a=%h b=%h want %h/%h", i, alu_a, alu_b, 32'h1234 + i, 32'h5678 + i); end
    end
    checks++; if (streak != 4) begin errors++; $display("FAIL pass_streak: got %0d want 4", streak); end
    dec_valid = 0;
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: got %b want 0", alu_valid); end
  endtask

  task automatic test_fwd_priority();
    drive_idle();
    alu_ready = 1; dec_valid = 1;
    dec_a_use = 1; dec_a_reg = 3; dec_a = 32'h1;
    dec_b_use = 0; dec_b_reg = 3; dec_b = 32'h2;
    ex_wr = 1; ex_dest = 3; ex_res = 32'hAAAA; ex_res_valid = 1;
    wb_wr = 1; wb_dest = 3; wb_res = 32'hBBBB;
    tick();
    checks++; if (alu_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_ex_over_wb: got %h want aaaa", alu_a); end
    checks++; if (alu_b !== 32'h2) begin errors++; $display("FAIL fwd_no_use: got %h want 2", alu_b); end
    ex_wr = 0;
    tick();
    checks++; if (alu_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_wb: got %h want bbbb", alu_a); end
    wb_wr = 0;
    tick();
    checks++; if (alu_a !== 32'h1) begin errors++; $display("FAIL fwd_dec: got %h want 1", alu_a); end
    drive_idle(); alu_ready = 1;
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    alu_ready = 1; dec_valid = 1;
    dec_b_use = 1; dec_b_reg = 7; dec_b = 32'h1;
    ex_wr = 1; ex_dest = 7; ex_res_valid = 0; ex_res = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready[%0d]: got %b want 0", i, dec_ready); end
      tick();
    end
    ex_res_valid = 1; ex_res = 32'h55;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b want 1", dec_ready); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL hazard_stall_cnt: got %0d want 3", stall_cnt); end
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_b !== 32'h55) begin
      errors++; $display("FAIL hazard_result: valid=%b b=%h want 1/55", alu_valid, alu_b); end
    drive_idle(); alu_ready = 1;
    tick();
  endtask

  task automatic test_snoop_hold();
    do_reset();
    dec_valid = 1; alu_ready = 0;
    dec_a_use = 1; dec_a_reg = 4; dec_a = 32'h10;
    dec_b_use = 0; dec_b_reg = 4; dec_b = 32'h20;
    dec_cin = 1; dec_cr = 32'hC0FFEE; dec_dest = 9; dec_dest_wr = 1;
    tick();
    drive_idle();
    wb_wr = 1; wb_dest = 4; wb_res = 32'h99;
    ex_wr = 1; ex_dest = 4; ex_res = 32'h77;
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_a !== 32'h99) begin
      errors++; $display("FAIL snoop_a: valid=%b a=%h want 1/99", alu_valid, alu_a); end
    checks++; if (alu_b !== 32'h20 || alu_cin !== 1'b1 || alu_cr !== 32'hC0FFEE || alu_dest !== 5'd9 || alu_dest_wr !== 1'b1) begin
      errors++; $display("FAIL snoop_other: b=%h cin=%b cr=%h dest=%0d wr=%b want 20/1/c0ffee/9/1",
                         alu_b, alu_cin, alu_cr, alu_dest, alu_dest_wr); end
    wb_wr = 0; ex_wr = 0;
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_a !== 32'h99) begin
      errors++; $display("FAIL hold_stable: valid=%b a=%h want 1/99", alu_valid, alu_a); end
  endtask

  // Runs straight after test_snoop_hold with the stage still FULL.
  task automatic test_flush();
    alu_ready = 1; dec_valid = 1; flush = 1; dec_a = 32'h5;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", dec_ready); end
    tick();
    flush = 0; dec_valid = 0;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", alu_valid); end
    tick();
  endtask

  task automatic test_random();
    bit     m_full = 0;
    entry_t m;
    int     m_stall = 0;
    int     bad = 0;
    bit     e_haz, e_rdy;
    m = '{default: '0};
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush        = ($urandom_range(0, 15) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      alu_ready    = ($urandom_range(0, 2) != 0);
      dec_a = $urandom; dec_b = $urandom; dec_cr = $urandom;
      dec_a_reg = 5'($urandom_range(0, 3)); dec_b_reg = 5'($urandom_range(0, 3));
      dec_a_use = 1'($urandom); dec_b_use = 1'($urandom);
      dec_cin = 1'($urandom); dec_dest = 5'($urandom); dec_dest_wr = 1'($urandom);
      ex_wr = 1'($urandom); ex_dest = 5'($urandom_range(0, 3)); ex_res = $urandom;
      ex_res_valid = ($urandom_range(0, 3) != 0);
      wb_wr = 1'($urandom); wb_dest = 5'($urandom_range(0, 3)); wb_res = $urandom;
      #1;
      e_haz = (m_hit(dec_a_use, dec_a_reg, ex_wr, ex_dest) || m_hit(dec_b_use, dec_b_reg, ex_wr, ex_dest))
              && !ex_res_valid;
      e_rdy = !flush && !e_haz && (!m_full || alu_ready);
      checks++; if (dec_ready !== e_rdy) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, dec_ready, e_rdy);
      end
      if (dec_valid && !e_rdy && m_stall < 65535) m_stall++;
      if (flush) m_full = 0;
      else if (dec_valid && e_rdy) begin
        m_full = 1;
        m.a = m_value(dec_a_use, dec_a_reg, dec_a);
        m.b = m_value(dec_b_use, dec_b_reg, dec_b);
        m.cin = dec_cin; m.cr = dec_cr; m.dest = dec_dest; m.dest_wr = dec_dest_wr;
        m.a_use = dec_a_use; m.a_reg = dec_a_reg; m.b_use = dec_b_use; m.b_reg = dec_b_reg;
      end else if (m_full && alu_ready) m_full = 0;
      else if (m_full) begin
        if (m_hit(m.a_use, m.a_reg, wb_wr, wb_dest)) m.a = wb_res;
        if (m_hit(m.b_use, m.b_reg, wb_wr, wb_dest)) m.b = wb_res;
      end
      tick();
      checks++; if (alu_valid !== m_full || stall_cnt !== 16'(m_stall)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_ctrl cyc %0d: valid=%b stall=%0d want %b/%0d", cyc, alu_valid, stall_cnt, m_full, m_stall);
      end
      if (m_full) begin
        checks++;
        if (alu_a !== m.a || alu_b !== m.b || alu_cin !== m.cin || alu_cr !== m.cr ||
            alu_dest !== m.dest || alu_dest_wr !== m.dest_wr) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rand_data cyc %0d: a=%h b=%h cin=%b cr=%h dest=%0d wr=%b want %h/%h/%b/%h/%0d/%b",
                                 cyc, alu_a, alu_b, alu_cin, alu_cr, alu_dest, alu_dest_wr,
                                 m.a, m.b, m.cin, m.cr, m.dest, m.dest_wr);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    // Permanent EX hazard keeps decode refused every cycle.
    dec_valid = 1; dec_a_use = 1; dec_a_reg = 1;
    ex_wr = 1; ex_dest = 1; ex_res_valid = 0;
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 100) begin
        checks++; if (stall_cnt !== 16'd100) begin errors++; $display("FAIL sat_early: got %0d want 100", stall_cnt); end
      end
      if (i == 65535) begin
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    flush = 1;
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_flush: got %h want ffff", stall_cnt); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fwd_priority();
    test_hazard();
    test_snoop_hold();
    test_flush();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
